// File: rtl/ved_mul_pkg.sv
// Shared constants for the multiplier arbiter: operand/result widths and FSM state encoding.
package ved_mul_pkg;
  localparam int OPW  = 16;
  localparam int RESW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/ved_mul_arbiter_if.sv
// Request/response bus between NUM_REQ clients and the shared multiplier arbiter.
interface ved_mul_arbiter_if
  import ved_mul_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [OPW*NUM_REQ-1:0] req_a;
  logic [OPW*NUM_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [RESW-1:0]        rsp_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/ved_16x16.sv
// Combinational 16x16 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from 2x2 cells.
module ved_16x16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  function automatic logic [3:0] ved2(input logic [1:0] a, input logic [1:0] b);
    logic       c;
    logic [3:0] p;
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    c    = (a[1] & b[0]) & (a[0] & b[1]);
    p[2] = (a[1] & b[1]) ^ c;
    p[3] = (a[1] & b[1]) & c;
    return p;
  endfunction

  function automatic logic [7:0] ved4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q0, q1, q2, q3;
    q0 = ved2(a[1:0], b[1:0]);
    q1 = ved2(a[3:2], b[1:0]);
    q2 = ved2(a[1:0], b[3:2]);
    q3 = ved2(a[3:2], b[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  function automatic logic [15:0] ved8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q0, q1, q2, q3;
    q0 = ved4(a[3:0], b[3:0]);
    q1 = ved4(a[7:4], b[3:0]);
    q2 = ved4(a[3:0], b[7:4]);
    q3 = ved4(a[7:4], b[7:4]);
    return {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
  endfunction

  logic [15:0] w_q0, w_q1, w_q2, w_q3;

  assign w_q0 = ved8(i_a[7:0],  i_b[7:0]);
  assign w_q1 = ved8(i_a[15:8], i_b[7:0]);
  assign w_q2 = ved8(i_a[7:0],  i_b[15:8]);
  assign w_q3 = ved8(i_a[15:8], i_b[15:8]);
  assign o_p  = {16'b0, w_q0} + {8'b0, w_q1, 8'b0} + {8'b0, w_q2, 8'b0} + {w_q3, 16'b0};
endmodule

// File: rtl/ved_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after i_rr_ptr, wrapping.
module ved_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_gnt_idx
);
  always_comb begin
    logic [ID_W-1:0] w_idx;
    o_grant   = '0;
    o_gnt_idx = '0;
    w_idx     = '0;
    // Walk from the farthest offset back to the pointer so the nearest valid wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (i_req_valid[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_gnt_idx      = w_idx;
      end
    end
  end
endmodule

// File: rtl/ved_mul_arbiter.sv
// Round-robin sharing of one ved_16x16 among NUM_REQ clients; IDLE -> MUL -> RESP.
// Optional VED_ARB_CHECK_EN adds a sticky chk_err comparing the multiplier to a behavioural product.
module ved_mul_arbiter
  import ved_mul_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ved_mul_arbiter_if.slave  bus,
`ifdef VED_ARB_CHECK_EN
  output logic              busy,
  output logic              chk_err
`else
  output logic              busy
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [OPW-1:0]    r_a;
  logic [OPW-1:0]    r_b;
  logic [RESW-1:0]   r_result;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_valid;
  logic              r_busy;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [RESW-1:0]    w_prod;
  logic               w_accept;
  logic [ID_W-1:0]    w_ptr_next;

  ved_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req_valid (bus.req_valid),
    .i_rr_ptr    (r_ptr),
    .o_grant     (w_grant),
    .o_gnt_idx   (w_gnt_idx)
  );

  ved_16x16 u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  // Ready is held low during reset so no client believes it was accepted.
  assign bus.req_ready  = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
  assign w_accept       = |(bus.req_valid & bus.req_ready);
  assign w_ptr_next     = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_result;
  assign busy           = r_busy;

`ifdef VED_ARB_CHECK_EN
  logic r_chk_err;
  assign chk_err = r_chk_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef VED_ARB_CHECK_EN
      r_chk_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        // accept stage: capture the granted client's operands
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.req_a[w_gnt_idx*OPW +: OPW];
            r_b     <= bus.req_b[w_gnt_idx*OPW +: OPW];
            r_id    <= w_gnt_idx;
            r_busy  <= 1'b1;
            r_state <= ST_MUL;
          end
        end
        // multiply stage: registered operands in, registered product out
        ST_MUL: begin
          r_result    <= w_prod;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
`ifdef VED_ARB_CHECK_EN
          if (w_prod != (RESW'(r_a) * RESW'(r_b))) r_chk_err <= 1'b1;
`endif
        end
        // response stage: hold until the consumer takes it
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
